// File: rtl/fpu_div16_if.sv
// fpu_div16_if: operand/result bundle for the FP16 divide unit.
//   master drives: start, fpuIn1 (dividend), fpuIn2 (divisor)
//   slave drives : fpuOut (quotient), done, condCodes {Z,C,N,V},
//                  statusFlags {invalid, divByZero, overflow, underflow, inexact}
// clock and reset stay outside the bundle as plain module ports.
interface fpu_div16_if;
  logic        start;
  logic [15:0] fpuIn1;
  logic [15:0] fpuIn2;
  logic [15:0] fpuOut;
  logic        done;
  logic [3:0]  condCodes;
  logic [4:0]  statusFlags;

  modport master (
    output start, fpuIn1, fpuIn2,
    input  fpuOut, done, condCodes, statusFlags
  );

  modport slave (
    input  start, fpuIn1, fpuIn2,
    output fpuOut, done, condCodes, statusFlags
  );
endinterface

// File: rtl/fpu_div16.sv
// fpu_div16: sequential IEEE-754 binary16 divider, fpuOut = fpuIn1 / fpuIn2.
// Radix-2 restoring significand division, one quotient bit per cycle,
// round to nearest / ties to even. Shares the start/done handshake and the
// condition-code / status-flag layout with the FP16 multiply unit.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-high; clears all state and outputs
//   bus   - fpu_div16_if slave: start, fpuIn1, fpuIn2 in;
//           fpuOut, done, condCodes, statusFlags out (non-zero only in DONE)
module fpu_div16 (
  input  logic       clock,
  input  logic       reset,
  fpu_div16_if.slave bus
);

  // 1 integer + 10 fraction + guard + round + 1 spare bit. The rounding
  // bit positions below are written for exactly this width.
  localparam int QBITS = 14;

  typedef enum logic [2:0] {IDLE, PREP, DIVIDE, ROUND, DONE} state_t;

  state_t state_reg, state_next;

  logic [15:0]       a_reg, b_reg;
  logic              sign_reg;
  logic signed [7:0] exp_reg;
  logic [11:0]       rem_reg;
  logic [11:0]       div_reg;
  logic [13:0]       q_reg;
  logic [3:0]        cnt_reg;
  logic [15:0]       out_reg;
  logic              done_reg;
  logic [3:0]        cc_reg;
  logic [4:0]        flags_reg;

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd11;
    found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 4'(10 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] cc_of(input logic [15:0] res, input logic ovf);
    return {~|res[14:0], 1'b0, res[15], ovf};
  endfunction

  // ---------------- operand decode (used in PREP) ----------------
  logic [4:0]        exp_a, exp_b;
  logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [10:0]       raw_a, raw_b, sig_a, sig_b;
  logic [3:0]        lz_a, lz_b;
  logic signed [7:0] eff_a, eff_b, exp_q;
  logic              sign_q;

  always_comb begin
    exp_a  = a_reg[14:10];
    exp_b  = b_reg[14:10];
    nan_a  = (&exp_a) & (|a_reg[9:0]);
    nan_b  = (&exp_b) & (|b_reg[9:0]);
    inf_a  = (&exp_a) & ~(|a_reg[9:0]);
    inf_b  = (&exp_b) & ~(|b_reg[9:0]);
    zero_a = ~(|exp_a) & ~(|a_reg[9:0]);
    zero_b = ~(|exp_b) & ~(|b_reg[9:0]);
    raw_a  = {|exp_a, a_reg[9:0]};
    raw_b  = {|exp_b, b_reg[9:0]};
    // Normals have lz = 0; subnormals get shifted up to a leading 1 and
    // their effective exponent becomes 1 - shift.
    lz_a   = lzc11(raw_a);
    lz_b   = lzc11(raw_b);
    sig_a  = raw_a << lz_a;
    sig_b  = raw_b << lz_b;
    eff_a  = $signed({3'b0, (|exp_a) ? exp_a : 5'd1}) - $signed({4'b0, lz_a});
    eff_b  = $signed({3'b0, (|exp_b) ? exp_b : 5'd1}) - $signed({4'b0, lz_b});
    exp_q  = eff_a - eff_b + 8'sd15;
    sign_q = a_reg[15] ^ b_reg[15];
  end

  // ---------------- special-case results, in priority order ----------------
  logic        spec_hit;
  logic [15:0] spec_res;
  logic [4:0]  spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = 16'h0000;
    spec_flags = 5'b00000;
    if (nan_a | nan_b) begin
      spec_res   = 16'h7E00;
      spec_flags = 5'b10000;
    end else if ((zero_a & zero_b) | (inf_a & inf_b)) begin
      spec_res   = 16'h7E00;
      spec_flags = 5'b10000;
    end else if (zero_b & ~inf_a) begin
      spec_res   = {sign_q, 15'h7C00};
      spec_flags = 5'b01000;
    end else if (inf_a) begin
      spec_res   = {sign_q, 15'h7C00};
    end else if (inf_b | zero_a) begin
      spec_res   = {sign_q, 15'h0000};
    end else begin
      spec_hit   = 1'b0;
    end
  end

  // ---------------- one restoring step (used in DIVIDE) ----------------
  // The divisor is held doubled so that the first "double then compare"
  // step yields the integer quotient bit (weight 1). The remainder then
  // always stays below div_reg and fits in 12 bits.
  logic [12:0] rem_dbl;
  logic        q_bit;
  logic [11:0] rem_new;

  always_comb begin
    rem_dbl = {rem_reg, 1'b0};
    q_bit   = (rem_dbl >= {1'b0, div_reg});
    rem_new = q_bit ? 12'(rem_dbl - {1'b0, div_reg}) : rem_dbl[11:0];
  end

  // ---------------- normalise / round (used in ROUND) ----------------
  logic [13:0]       qn;
  logic signed [7:0] en, e_r, sh;
  logic              st0, g, rd, inc;
  logic [10:0]       mant;
  logic [11:0]       mant_r;
  logic [9:0]        mant_f;
  logic [3:0]        sh_c;
  logic [25:0]       wide;
  logic [12:0]       vs;
  logic              stk, g2, r2, inc2, inx2;
  logic [10:0]       frac, frac_r;
  logic [15:0]       rnd_res;
  logic [4:0]        rnd_flags;

  always_comb begin
    qn  = q_reg[13] ? q_reg : {q_reg[12:0], 1'b0};
    en  = q_reg[13] ? exp_reg : exp_reg - 8'sd1;
    // Bit 0 sits below the round bit when no shift happened, so it joins
    // the sticky together with the leftover remainder.
    st0 = qn[0] | (|rem_reg);

    mant   = qn[13:3];
    g      = qn[2];
    rd     = qn[1];
    inc    = g & (rd | st0 | mant[0]);
    mant_r = {1'b0, mant} + 12'(inc);
    e_r    = en + $signed({7'b0, mant_r[11]});
    mant_f = mant_r[11] ? mant_r[10:1] : mant_r[9:0];

    // Subnormal result: shift right by 1-e; beyond 13 places every bit of
    // the value lands in the sticky, so the shift is clamped there.
    sh     = 8'sd1 - en;
    sh_c   = (sh > 8'sd14) ? 4'd14 : sh[3:0];
    wide   = {qn[13:1], 13'b0} >> sh_c;
    vs     = wide[25:13];
    stk    = st0 | (|wide[12:0]);
    frac   = vs[12:2];
    g2     = vs[1];
    r2     = vs[0];
    inc2   = g2 & (r2 | stk | frac[0]);
    // A carry to 1024 lands in the exponent LSB: smallest normal.
    frac_r = frac + 11'(inc2);
    inx2   = g2 | r2 | stk;

    if (en >= 8'sd1) begin
      if (e_r >= 8'sd31) begin
        rnd_res   = {sign_reg, 15'h7C00};
        rnd_flags = 5'b00101;
      end else begin
        rnd_res   = {sign_reg, e_r[4:0], mant_f};
        rnd_flags = {4'b0, g | rd | st0};
      end
    end else begin
      rnd_res   = {sign_reg, 4'b0, frac_r};
      rnd_flags = {3'b0, inx2, inx2};
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = PREP;
      PREP:    state_next = spec_hit ? DONE : DIVIDE;
      DIVIDE:  if (cnt_reg == 4'd0) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (bus.start) state_next = PREP;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sign_reg  <= 1'b0;
      exp_reg   <= '0;
      rem_reg   <= '0;
      div_reg   <= '0;
      q_reg     <= '0;
      cnt_reg   <= '0;
      out_reg   <= '0;
      done_reg  <= 1'b0;
      cc_reg    <= '0;
      flags_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg <= bus.fpuIn1;
            b_reg <= bus.fpuIn2;
          end
        end
        PREP: begin
          sign_reg <= sign_q;
          exp_reg  <= exp_q;
          rem_reg  <= {1'b0, sig_a};
          div_reg  <= {sig_b, 1'b0};
          q_reg    <= '0;
          cnt_reg  <= 4'(QBITS - 1);
          if (spec_hit) begin
            out_reg   <= spec_res;
            flags_reg <= spec_flags;
            cc_reg    <= cc_of(spec_res, spec_flags[2]);
            done_reg  <= 1'b1;
          end
        end
        DIVIDE: begin
          rem_reg <= rem_new;
          q_reg   <= {q_reg[12:0], q_bit};
          cnt_reg <= cnt_reg - 4'd1;
        end
        ROUND: begin
          out_reg   <= rnd_res;
          flags_reg <= rnd_flags;
          cc_reg    <= cc_of(rnd_res, rnd_flags[2]);
          done_reg  <= 1'b1;
        end
        DONE: begin
          if (bus.start) begin
            a_reg     <= bus.fpuIn1;
            b_reg     <= bus.fpuIn2;
            out_reg   <= '0;
            flags_reg <= '0;
            cc_reg    <= '0;
            done_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fpuOut      = out_reg;
  assign bus.done        = done_reg;
  assign bus.condCodes   = cc_reg;
  assign bus.statusFlags = flags_reg;

endmodule

// File: tb/tb_fpu_div16.sv
// tb_fpu_div16: self-checking bench for fpu_div16.
// A table of {operands, expected quotient/flags/condCodes/latency} records is
// applied in a loop; each expectation is pushed to a scoreboard queue when the
// operands are driven and popped when done rises. Latency is counted in
// falling edges after the clock edge that samples start (normal path 17,
// special path 2). Hand-written sequences cover reset mid-divide and a
// back-to-back start held through DONE.
module tb_fpu_div16;
  logic clock = 1'b0;
  logic reset = 1'b1;

  fpu_div16_if bus();

  fpu_div16 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [4:0]  flags;
    logic [3:0]  cc;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input string n, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] o, input logic [4:0] f,
                              input logic [3:0] c, input int l);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.out = o; v.flags = f; v.cc = c; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    @(negedge clock);
    bus.start  = 1'b1;
    bus.fpuIn1 = v.a;
    bus.fpuIn2 = v.b;
    sb.push_back(v);
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // n0 = falling edges already consumed since the start-sampling edge.
  task automatic wait_result(input int n0);
    int   n;
    bit   got;
    vec_t e;
    n   = n0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clock);
      n++;
      got = (bus.done === 1'b1);
    end
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard: result with no expected entry, got %h", bus.fpuOut);
      return;
    end
    e = sb.pop_front();
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s/timeout: done not seen after %0d cycles, required at %0d", e.name, n, e.lat);
      return;
    end
    $display("op %-10s %h / %h -> %h flags %b cc %b after %0d cycles",
             e.name, e.a, e.b, bus.fpuOut, bus.statusFlags, bus.condCodes, n);
    chk($sformatf("%s/latency", e.name), n, e.lat);
    chk($sformatf("%s/out", e.name), bus.fpuOut, e.out);
    chk($sformatf("%s/flags", e.name), bus.statusFlags, e.flags);
    chk($sformatf("%s/cc", e.name), bus.condCodes, e.cc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v1;
    vec_t v2;
    vec_t e;

    bus.start  = 1'b0;
    bus.fpuIn1 = 16'h0000;
    bus.fpuIn2 = 16'h0000;

    //                name          a        b        out      flags     cc{ZCNV} lat
    vecs.push_back(mk("3/2",        16'h4200, 16'h4000, 16'h3E00, 5'b00000, 4'b0000, 17));
    vecs.push_back(mk("1/3",        16'h3C00, 16'h4200, 16'h3555, 5'b00001, 4'b0000, 17));
    vecs.push_back(mk("-2/0",       16'hC000, 16'h0000, 16'hFC00, 5'b01000, 4'b0010, 2));
    vecs.push_back(mk("max/0.5",    16'h7BFF, 16'h3800, 16'h7C00, 5'b00101, 4'b0001, 17));
    vecs.push_back(mk("0/0",        16'h0000, 16'h0000, 16'h7E00, 5'b10000, 4'b0000, 2));
    vecs.push_back(mk("tiny/2",     16'h0001, 16'h4000, 16'h0000, 5'b00011, 4'b1000, 17));
    vecs.push_back(mk("nan/1",      16'h7E00, 16'h3C00, 16'h7E00, 5'b10000, 4'b0000, 2));
    vecs.push_back(mk("inf/-inf",   16'h7C00, 16'hFC00, 16'h7E00, 5'b10000, 4'b0000, 2));
    vecs.push_back(mk("-inf/2",     16'hFC00, 16'h4000, 16'hFC00, 5'b00000, 4'b0010, 2));
    vecs.push_back(mk("inf/0",      16'h7C00, 16'h0000, 16'h7C00, 5'b00000, 4'b0000, 2));
    vecs.push_back(mk("1/-inf",     16'h3C00, 16'hFC00, 16'h8000, 5'b00000, 4'b1010, 2));
    vecs.push_back(mk("-0/2",       16'h8000, 16'h4000, 16'h8000, 5'b00000, 4'b1010, 2));
    vecs.push_back(mk("-4/2",       16'hC400, 16'h4000, 16'hC000, 5'b00000, 4'b0010, 17));
    vecs.push_back(mk("minnorm/2",  16'h0400, 16'h4000, 16'h0200, 5'b00000, 4'b0000, 17));
    vecs.push_back(mk("1/1+ulp",    16'h3C00, 16'h3C01, 16'h3BFE, 5'b00001, 4'b0000, 17));
    vecs.push_back(mk("5/3",        16'h4500, 16'h4200, 16'h3EAB, 5'b00001, 4'b0000, 17));
    vecs.push_back(mk("big/tiny",   16'h7800, 16'h0001, 16'h7C00, 5'b00101, 4'b0001, 17));
    vecs.push_back(mk("3tiny/2",    16'h0003, 16'h4000, 16'h0002, 5'b00011, 4'b0000, 17));

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset/done",  bus.done, 1'b0);
    chk("reset/out",   bus.fpuOut, 16'h0000);
    chk("reset/cc",    bus.condCodes, 4'h0);
    chk("reset/flags", bus.statusFlags, 5'h00);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle/done", bus.done, 1'b0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      start_op(vecs[i]);
      wait_result(0);
    end

    // Reset asserted at edge T+8, in the middle of DIVIDE
    v1 = vecs[0];
    start_op(v1);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midreset/done", bus.done, 1'b0);
    chk("midreset/out",  bus.fpuOut, 16'h0000);
    sb.delete();
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("midreset/stays_idle", bus.done, 1'b0);
    start_op(v1);
    wait_result(0);

    // Back-to-back: start held high through DONE
    v1 = vecs[2];  // -2/0, special path
    v2 = vecs[15]; // 5/3, normal path
    @(negedge clock);
    bus.start  = 1'b1;
    bus.fpuIn1 = v1.a;
    bus.fpuIn2 = v1.b;
    sb.push_back(v1);
    @(posedge clock);
    #1;
    bus.fpuIn1 = v2.a;
    bus.fpuIn2 = v2.b;
    @(negedge clock);
    chk("b2b/first_pending", bus.done, 1'b0);
    @(negedge clock);
    chk("b2b/first_done", bus.done, 1'b1);
    e = sb.pop_front();
    $display("op b2b-first %h / %h -> %h flags %b cc %b", e.a, e.b, bus.fpuOut, bus.statusFlags, bus.condCodes);
    chk("b2b/first_out",   bus.fpuOut, e.out);
    chk("b2b/first_flags", bus.statusFlags, e.flags);
    sb.push_back(v2);
    @(posedge clock);
    #1 bus.start = 1'b0;
    @(negedge clock);
    chk("b2b/done_drop", bus.done, 1'b0);
    chk("b2b/out_clear", bus.fpuOut, 16'h0000);
    wait_result(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
